// File: rtl/lfsr_pkg.sv
// Shared constants and types for the 8-bit LFSR generator/checker pair.
// Holds the feedback taps, the generator seed and the checker state encoding.
package lfsr_pkg;

    localparam int TAP_A = 7;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;

    localparam logic [7:0] LFSR_SEED = 8'h0F;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } checker_state_t;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance: shift left, feed the tap XOR into bit 0.
// Shared by the checker's predictor and any generator built on the same taps.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    assign nxt = {cur[6:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};

endmodule

// File: rtl/lfsr_checker.sv
// Synchronises to an incoming 8-bit LFSR stream, tracks lock and counts
// mismatching samples while locked; all outputs are registered.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        clear_err,
    output logic        locked,
    output logic        sample_err,
    output logic [15:0] err_count
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    checker_state_t state, state_next;
    logic [7:0]  ref_reg, ref_next;
    logic [7:0]  predicted;
    logic [3:0]  match_cnt, match_next, match_inc;
    logic [3:0]  miss_cnt, miss_next, miss_inc;
    logic        locked_next, serr_next, is_match;
    logic [15:0] err_next;

    lfsr_step u_predict (
        .cur (ref_reg),
        .nxt (predicted)
    );

    assign is_match  = (in_data == predicted);
    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= SEEK;
            ref_reg    <= 8'h00;
            match_cnt  <= 4'd0;
            miss_cnt   <= 4'd0;
            locked     <= 1'b0;
            sample_err <= 1'b0;
            err_count  <= 16'h0000;
        end else begin
            state      <= state_next;
            ref_reg    <= ref_next;
            match_cnt  <= match_next;
            miss_cnt   <= miss_next;
            locked     <= locked_next;
            sample_err <= serr_next;
            err_count  <= err_next;
        end
    end

    // While locked a mismatch flywheels the reference instead of reseeding,
    // so a single corrupted sample does not knock the predictor off the stream.
    always_comb begin
        state_next  = state;
        ref_next    = ref_reg;
        match_next  = match_cnt;
        miss_next   = miss_cnt;
        locked_next = locked;
        serr_next   = 1'b0;
        err_next    = err_count;

        if (in_valid) begin
            case (state)
                SEEK: begin
                    if (in_data != 8'h00) begin
                        ref_next   = in_data;
                        match_next = 4'd0;
                        state_next = TRACK;
                    end
                end
                TRACK: begin
                    if (is_match) begin
                        ref_next   = in_data;
                        match_next = match_inc;
                        if (match_inc == LOCK_CNT) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                            miss_next   = 4'd0;
                        end
                    end else begin
                        match_next = 4'd0;
                        if (in_data == 8'h00) begin
                            state_next = SEEK;
                        end else begin
                            ref_next = in_data;
                        end
                    end
                end
                LOCKED: begin
                    if (is_match) begin
                        ref_next  = in_data;
                        miss_next = 4'd0;
                    end else begin
                        ref_next  = predicted;
                        serr_next = 1'b1;
                        miss_next = miss_inc;
                        if (err_count != 16'hFFFF) begin
                            err_next = err_count + 16'd1;
                        end
                        if (miss_inc == LOSS_CNT) begin
                            state_next  = SEEK;
                            locked_next = 1'b0;
                            miss_next   = 4'd0;
                            match_next  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_next  = SEEK;
                    locked_next = 1'b0;
                end
            endcase
        end

        if (clear_err) begin
            err_next = 16'h0000;
        end
    end

endmodule
